// File: rtl/debug_bridge_pkg.sv
// Shared definitions for the debug bridge: command codes, response constants
// and the controller state encoding.
package debug_bridge_pkg;

   localparam logic [7:0] CMD_NOP         = 8'h00;
   localparam logic [7:0] CMD_ECHO        = 8'h01;
   localparam logic [7:0] CMD_MEM_WRITE   = 8'h02;
   localparam logic [7:0] CMD_MEM_READ    = 8'h03;
   localparam logic [7:0] CMD_VALUE_WRITE = 8'h04;
   localparam logic [7:0] CMD_VALUE_READ  = 8'h05;
   localparam logic [7:0] CMD_MEM_FILL    = 8'h06;

   localparam logic [7:0] ERR_BYTE = 8'hEE;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_WR_DATA,
      ST_FILL,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_VAL_WAIT,
      ST_TX
   } state_t;

   function automatic logic is_cmd(input logic [7:0] c);
      return (c >= CMD_ECHO) && (c <= CMD_MEM_FILL);
   endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Loads a VALUE_BYTES word and sends i_nbytes of it MSB first over a
// ready/valid byte stream; o_last flags acceptance of the final byte.
module debug_tx_serializer #(
   parameter int VALUE_BYTES = 2,
   localparam int VW = 8 * VALUE_BYTES,
   localparam int CW = $clog2(VALUE_BYTES + 1)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_load,
   input  logic [VW-1:0] i_word,
   input  logic [CW-1:0] i_nbytes,
   input  logic          i_tx_ready,
   output logic          o_tx_dv,
   output logic [7:0]    o_tx_byte,
   output logic          o_last
);

   logic [VW-1:0] r_word;
   logic [CW-1:0] r_cnt;
   logic          w_accept;

   assign o_tx_dv   = (r_cnt != '0);
   assign w_accept  = o_tx_dv && i_tx_ready;
   assign o_tx_byte = o_tx_dv ? r_word[VW-1 -: 8] : 8'h00;
   assign o_last    = w_accept && (r_cnt == CW'(1));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_word <= i_word;
         r_cnt  <= i_nbytes;
      end else if (w_accept) begin
         r_word <= r_word << 8;
         r_cnt  <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/debug_bridge.sv
// Byte-stream debug bridge: decodes rx command packets into memory and value
// bus accesses and returns read data / echoes / errors on the tx stream.
module debug_bridge
   import debug_bridge_pkg::*;
#(
   parameter int ADDR_BYTES     = 2,
   parameter int LEN_BYTES      = 2,
   parameter int VALUE_BYTES    = 2,
   parameter int MEM_RD_LATENCY = 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_rx_dv,
   input  logic [7:0]                i_rx_byte,
   output logic                      o_tx_dv,
   output logic [7:0]                o_tx_byte,
   input  logic                      i_tx_ready,
   output logic [8*ADDR_BYTES-1:0]   o_mem_address,
   output logic                      o_mem_rw,
   output logic                      o_mem_en,
   output logic [7:0]                o_mem_data,
   input  logic [7:0]                i_mem_data,
   output logic [15:0]               o_value_id,
   output logic                      o_value_rw,
   output logic                      o_value_en,
   output logic [8*VALUE_BYTES-1:0]  o_value_data,
   input  logic [8*VALUE_BYTES-1:0]  i_value_data,
   output logic [7:0]                o_debug_cmd,
   output logic [8*LEN_BYTES-1:0]    o_bytes_remaining,
   output logic                      o_busy,
   output logic                      o_rx_overrun
);

   localparam int AW = 8 * ADDR_BYTES;
   localparam int LW = 8 * LEN_BYTES;
   localparam int VW = 8 * VALUE_BYTES;
   localparam int CW = $clog2(VALUE_BYTES + 1);
   localparam logic [3:0] HDR_A   = 4'(ADDR_BYTES);
   localparam logic [3:0] HDR_MEM = 4'(ADDR_BYTES + LEN_BYTES);
   localparam logic [3:0] HDR_VAL = 4'(2 + VALUE_BYTES);
   localparam logic [1:0] RD_WAIT_INIT = 2'(MEM_RD_LATENCY - 1);

   state_t         r_state, w_next;
   logic [7:0]     r_cmd;
   logic [3:0]     r_hdr_cnt;
   logic [AW-1:0]  r_addr;
   logic [LW-1:0]  r_len;
   logic [LW-1:0]  r_remaining;
   logic [7:0]     r_wr_data;
   logic           r_wr_pulse;
   logic [15:0]    r_val_id;
   logic [VW-1:0]  r_val;
   logic           r_val_en;
   logic           r_val_wr;
   logic [1:0]     r_lat;
   logic           r_overrun;

   logic           w_busy, w_rx, w_hdr_last, w_mem_wr, w_val_cmd, w_mem_cmd;
   logic [3:0]     w_hdr_len;
   logic [LW-1:0]  w_len_full, w_len_hdr;
   logic           w_ser_load, w_ser_last;
   logic [VW-1:0]  w_ser_word;
   logic [CW-1:0]  w_ser_n;

   function automatic logic [VW-1:0] msb_word(input logic [7:0] b);
      return VW'(b) << (VW - 8);
   endfunction

   assign w_busy     = !(r_state inside {ST_IDLE, ST_HDR, ST_WR_DATA});
   assign w_rx       = i_rx_dv && !w_busy;
   assign w_val_cmd  = (r_cmd == CMD_VALUE_WRITE) || (r_cmd == CMD_VALUE_READ);
   assign w_mem_cmd  = (r_cmd == CMD_MEM_WRITE) || (r_cmd == CMD_MEM_READ) ||
                       (r_cmd == CMD_MEM_FILL);
   // For write/read the final header byte is the length LSB, still in flight.
   assign w_len_full = (r_len << 8) | LW'(i_rx_byte);
   assign w_len_hdr  = (r_cmd == CMD_MEM_FILL) ? r_len : w_len_full;

   always_comb begin
      case (r_cmd)
         CMD_MEM_WRITE, CMD_MEM_READ: w_hdr_len = HDR_MEM;
         CMD_MEM_FILL:                w_hdr_len = HDR_MEM + 4'd1;
         CMD_VALUE_WRITE:             w_hdr_len = HDR_VAL;
         CMD_VALUE_READ:              w_hdr_len = 4'd2;
         default:                     w_hdr_len = 4'd1;
      endcase
   end

   assign w_hdr_last = (r_state == ST_HDR) && w_rx && (r_hdr_cnt == w_hdr_len - 4'd1);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_ser_load = 1'b0;
      w_ser_word = '0;
      w_ser_n    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_rx && is_cmd(i_rx_byte)) begin
               w_next = ST_HDR;
            end else if (w_rx && i_rx_byte != CMD_NOP) begin
               w_next     = ST_TX;
               w_ser_load = 1'b1;
               w_ser_word = msb_word(ERR_BYTE);
               w_ser_n    = CW'(1);
            end
         end
         ST_HDR: begin
            if (w_hdr_last) begin
               case (r_cmd)
                  CMD_ECHO: begin
                     w_next     = ST_TX;
                     w_ser_load = 1'b1;
                     w_ser_word = msb_word(i_rx_byte);
                     w_ser_n    = CW'(1);
                  end
                  CMD_MEM_WRITE:  w_next = (w_len_hdr == '0) ? ST_IDLE : ST_WR_DATA;
                  CMD_MEM_READ:   w_next = (w_len_hdr == '0) ? ST_IDLE : ST_RD_ISSUE;
                  CMD_MEM_FILL:   w_next = (w_len_hdr == '0) ? ST_IDLE : ST_FILL;
                  CMD_VALUE_READ: w_next = ST_VAL_WAIT;
                  default:        w_next = ST_IDLE;
               endcase
            end
         end
         ST_WR_DATA: if (w_rx && r_remaining == LW'(1)) w_next = ST_IDLE;
         ST_FILL:    if (r_remaining == LW'(1)) w_next = ST_IDLE;
         ST_RD_ISSUE: w_next = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (r_lat == 2'd0) begin
               w_next     = ST_TX;
               w_ser_load = 1'b1;
               w_ser_word = msb_word(i_mem_data);
               w_ser_n    = CW'(1);
            end
         end
         ST_VAL_WAIT: begin
            if (r_lat == 2'd0) begin
               w_next     = ST_TX;
               w_ser_load = 1'b1;
               w_ser_word = i_value_data;
               w_ser_n    = CW'(VALUE_BYTES);
            end
         end
         ST_TX: begin
            if (w_ser_last)
               w_next = (r_cmd == CMD_MEM_READ && r_remaining != '0) ? ST_RD_ISSUE : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Header capture: multi-byte fields shift in big-endian.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cmd     <= CMD_NOP;
         r_hdr_cnt <= '0;
         r_len     <= '0;
         r_val_id  <= '0;
         r_val     <= '0;
      end else if (r_state == ST_IDLE && w_rx && i_rx_byte != CMD_NOP) begin
         r_cmd     <= i_rx_byte;
         r_hdr_cnt <= '0;
      end else if (r_state == ST_HDR && w_rx) begin
         r_hdr_cnt <= r_hdr_cnt + 4'd1;
         if (w_val_cmd) begin
            if (r_hdr_cnt < 4'd2) r_val_id <= {r_val_id[7:0], i_rx_byte};
            else                  r_val    <= (r_val << 8) | VW'(i_rx_byte);
         end else if (w_mem_cmd && r_hdr_cnt >= HDR_A && r_hdr_cnt < HDR_MEM) begin
            r_len <= (r_len << 8) | LW'(i_rx_byte);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_addr <= '0;
      end else if (r_state == ST_HDR && w_rx && w_mem_cmd && r_hdr_cnt < HDR_A) begin
         r_addr <= (r_addr << 8) | AW'(i_rx_byte);
      end else if (w_mem_wr || (r_state == ST_TX && w_ser_last && r_cmd == CMD_MEM_READ)) begin
         r_addr <= r_addr + AW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_remaining <= '0;
         r_wr_pulse  <= 1'b0;
         r_wr_data   <= '0;
         r_val_en    <= 1'b0;
         r_val_wr    <= 1'b0;
         r_lat       <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun  <= i_rx_dv && w_busy;
         r_wr_pulse <= (r_state == ST_WR_DATA) && w_rx;
         r_val_en   <= w_hdr_last && w_val_cmd;
         r_val_wr   <= w_hdr_last && (r_cmd == CMD_VALUE_WRITE);

         if (r_state == ST_WR_DATA && w_rx)
            r_wr_data <= i_rx_byte;
         else if (w_hdr_last && r_cmd == CMD_MEM_FILL)
            r_wr_data <= i_rx_byte;

         if (w_hdr_last && w_mem_cmd)
            r_remaining <= w_len_hdr;
         else if ((r_state == ST_WR_DATA && w_rx) || r_state == ST_FILL || r_state == ST_RD_ISSUE)
            r_remaining <= r_remaining - LW'(1);

         // Value reads see data one cycle after the enable pulse.
         if (w_hdr_last && r_cmd == CMD_VALUE_READ)
            r_lat <= 2'd1;
         else if (r_state == ST_RD_ISSUE)
            r_lat <= RD_WAIT_INIT;
         else if ((r_state == ST_RD_WAIT || r_state == ST_VAL_WAIT) && r_lat != 2'd0)
            r_lat <= r_lat - 2'd1;
      end
   end

   debug_tx_serializer #(.VALUE_BYTES(VALUE_BYTES)) u_ser (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_load     (w_ser_load),
      .i_word     (w_ser_word),
      .i_nbytes   (w_ser_n),
      .i_tx_ready (i_tx_ready),
      .o_tx_dv    (o_tx_dv),
      .o_tx_byte  (o_tx_byte),
      .o_last     (w_ser_last)
   );

   assign w_mem_wr          = r_wr_pulse || (r_state == ST_FILL);
   assign o_mem_en          = w_mem_wr || (r_state == ST_RD_ISSUE);
   assign o_mem_rw          = w_mem_wr ? RW_WRITE : RW_READ;
   assign o_mem_address     = o_mem_en ? r_addr : '0;
   assign o_mem_data        = w_mem_wr ? r_wr_data : 8'h00;

   assign o_value_en        = r_val_en;
   assign o_value_rw        = (r_val_en && r_val_wr) ? RW_WRITE : RW_READ;
   assign o_value_id        = r_val_en ? r_val_id : 16'h0000;
   assign o_value_data      = (r_val_en && r_val_wr) ? r_val : '0;

   assign o_debug_cmd       = (r_state == ST_IDLE) ? CMD_NOP : r_cmd;
   assign o_bytes_remaining = r_remaining;
   assign o_busy            = w_busy;
   assign o_rx_overrun      = r_overrun;

endmodule

// File: tb/tb_debug_bridge.sv
// Directed bench for debug_bridge: byte-level packets in, tx/memory/value
// traffic logged by monitors and checked against hand-computed values.
module tb_debug_bridge;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_rx_dv = 1'b0;
   logic [7:0]  i_rx_byte = 8'h00;
   logic        i_tx_ready = 1'b1;
   logic        o_tx_dv;
   logic [7:0]  o_tx_byte;
   logic [15:0] o_mem_address;
   logic        o_mem_rw, o_mem_en;
   logic [7:0]  o_mem_data;
   logic [7:0]  i_mem_data;
   logic [15:0] o_value_id;
   logic        o_value_rw, o_value_en;
   logic [31:0] o_value_data;
   logic [31:0] i_value_data = 32'hDEADBEEF;
   logic [7:0]  o_debug_cmd;
   logic [15:0] o_bytes_remaining;
   logic        o_busy, o_rx_overrun;

   debug_bridge #(.ADDR_BYTES(2), .LEN_BYTES(2), .VALUE_BYTES(4), .MEM_RD_LATENCY(2)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
      .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .i_tx_ready(i_tx_ready),
      .o_mem_address(o_mem_address), .o_mem_rw(o_mem_rw), .o_mem_en(o_mem_en),
      .o_mem_data(o_mem_data), .i_mem_data(i_mem_data),
      .o_value_id(o_value_id), .o_value_rw(o_value_rw), .o_value_en(o_value_en),
      .o_value_data(o_value_data), .i_value_data(i_value_data),
      .o_debug_cmd(o_debug_cmd), .o_bytes_remaining(o_bytes_remaining),
      .o_busy(o_busy), .o_rx_overrun(o_rx_overrun)
   );

   always #5 i_clk = ~i_clk;

   // Synchronous memory with two-cycle read latency.
   logic [7:0] mem [0:65535];
   logic [7:0] rd_pipe [0:1];
   always @(posedge i_clk) begin
      if (o_mem_en && !o_mem_rw) mem[o_mem_address] <= o_mem_data;
      rd_pipe[0] <= (o_mem_en && o_mem_rw) ? mem[o_mem_address] : 8'h00;
      rd_pipe[1] <= rd_pipe[0];
   end
   assign i_mem_data = rd_pipe[1];

   // Monitors sample mid-cycle.
   logic [7:0]  tx_q [$];
   logic [23:0] wr_q [$];
   int          wr_cyc [$];
   logic [48:0] val_q [$];
   int cyc, rd_n, ovr_n, wr_idle, stab_err;
   logic       prev_dv, prev_rdy;
   logic [7:0] prev_byte;

   always @(negedge i_clk) begin
      cyc <= cyc + 1;
      if (i_reset_n) begin
         if (o_tx_dv && i_tx_ready) tx_q.push_back(o_tx_byte);
         if (o_mem_en && !o_mem_rw) begin
            wr_q.push_back({o_mem_address, o_mem_data});
            wr_cyc.push_back(cyc);
            if (!o_busy) wr_idle <= wr_idle + 1;
         end
         if (o_mem_en && o_mem_rw) rd_n <= rd_n + 1;
         if (o_rx_overrun) ovr_n <= ovr_n + 1;
         if (o_value_en) val_q.push_back({o_value_rw, o_value_id, o_value_data});
         if (prev_dv && !prev_rdy && (o_tx_dv !== 1'b1 || o_tx_byte !== prev_byte))
            stab_err <= stab_err + 1;
         prev_dv   <= o_tx_dv;
         prev_rdy  <= i_tx_ready;
         prev_byte <= o_tx_byte;
      end
   end

   int n_checks = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      i_rx_dv = 1'b1;
      i_rx_byte = b;
      tick();
      i_rx_dv = 1'b0;
      i_rx_byte = 8'h00;
   endtask

   task automatic wait_tx(input int n, input string tag);
      int k = 0;
      while (tx_q.size() < n && k < 200) begin
         tick();
         k++;
      end
      chk(tag, 64'(tx_q.size() >= n), 64'd1);
   endtask

   function automatic logic [63:0] txb(input int i);
      if (i < tx_q.size()) return 64'(tx_q[i]);
      return 'x;
   endfunction

   function automatic logic [63:0] wrb(input int i);
      if (i < wr_q.size()) return 64'(wr_q[i]);
      return 'x;
   endfunction

   function automatic logic [63:0] valb(input int i);
      if (i < val_q.size()) return 64'(val_q[i]);
      return 'x;
   endfunction

   initial begin
      int tb, wb, rb, ob, ib, vb;

      repeat (3) tick();
      chk("rst_tx_dv",    64'(o_tx_dv), 64'd0);
      chk("rst_tx_byte",  64'(o_tx_byte), 64'd0);
      chk("rst_mem_en",   64'(o_mem_en), 64'd0);
      chk("rst_mem_rw",   64'(o_mem_rw), 64'd1);
      chk("rst_mem_addr", 64'(o_mem_address), 64'd0);
      chk("rst_val_en",   64'(o_value_en), 64'd0);
      chk("rst_val_rw",   64'(o_value_rw), 64'd1);
      chk("rst_busy",     64'(o_busy), 64'd0);
      chk("rst_overrun",  64'(o_rx_overrun), 64'd0);
      chk("rst_cmd",      64'(o_debug_cmd), 64'd0);
      chk("rst_remain",   64'(o_bytes_remaining), 64'd0);
      i_reset_n = 1'b1;
      tick();

      // ECHO held off by the sink for 10 cycles
      i_tx_ready = 1'b0;
      tb = tx_q.size();
      send(8'h01); send(8'h5A);
      chk("echo_dv",   64'(o_tx_dv), 64'd1);
      chk("echo_byte", 64'(o_tx_byte), 64'h5A);
      chk("echo_cmd",  64'(o_debug_cmd), 64'h01);
      chk("echo_busy", 64'(o_busy), 64'd1);
      repeat (10) tick();
      chk("echo_hold",    64'(o_tx_byte), 64'h5A);
      chk("echo_no_xfer", 64'(tx_q.size() - tb), 64'd0);
      i_tx_ready = 1'b1;
      repeat (4) tick();
      chk("echo_xfer_n",  64'(tx_q.size() - tb), 64'd1);
      chk("echo_xfer_b",  txb(tb), 64'h5A);
      chk("echo_stable",  64'(stab_err), 64'd0);
      chk("echo_cmd_nop", 64'(o_debug_cmd), 64'h00);

      // MEM_WRITE wrapping past 0xFFFF
      wb = wr_q.size();
      send(8'h02); send(8'hFF); send(8'hFF); send(8'h00); send(8'h02);
      chk("mw_remain", 64'(o_bytes_remaining), 64'd2);
      chk("mw_cmd",    64'(o_debug_cmd), 64'h02);
      send(8'h11); send(8'h22);
      repeat (2) tick();
      chk("mw_n",      64'(wr_q.size() - wb), 64'd2);
      chk("mw_w0",     wrb(wb),     64'h00FFFF11);
      chk("mw_w1",     wrb(wb + 1), 64'h00000022);
      chk("mw_remain0", 64'(o_bytes_remaining), 64'd0);

      // Preload 0x0100..0x0102, then MEM_READ them back
      send(8'h02); send(8'h01); send(8'h00); send(8'h00); send(8'h03);
      send(8'hA0); send(8'hA1); send(8'hA2);
      repeat (2) tick();
      tb = tx_q.size();
      rb = rd_n;
      send(8'h03); send(8'h01); send(8'h00); send(8'h00); send(8'h03);
      wait_tx(tb + 3, "mr_timeout");
      repeat (4) tick();
      chk("mr_b0",     txb(tb),     64'hA0);
      chk("mr_b1",     txb(tb + 1), 64'hA1);
      chk("mr_b2",     txb(tb + 2), 64'hA2);
      chk("mr_pulses", 64'(rd_n - rb), 64'd3);
      chk("mr_busy",   64'(o_busy), 64'd0);

      // MEM_FILL with an rx byte arriving mid-fill
      wb = wr_q.size(); ob = ovr_n; ib = wr_idle; tb = tx_q.size();
      send(8'h06); send(8'h00); send(8'h10); send(8'h00); send(8'h04); send(8'hCC);
      chk("fill_busy", 64'(o_busy), 64'd1);
      send(8'h99);
      repeat (6) tick();
      chk("fill_n", 64'(wr_q.size() - wb), 64'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("fill_w%0d", i), wrb(wb + i), 64'({16'h0010 + 16'(i), 8'hCC}));
      chk("fill_consec", 64'(wr_cyc[wb + 3] - wr_cyc[wb]), 64'd3);
      chk("fill_busy_all", 64'(wr_idle - ib), 64'd0);
      chk("fill_overrun",  64'(ovr_n - ob), 64'd1);
      chk("fill_discard",  64'(tx_q.size() - tb), 64'd0);

      // VALUE_READ id 3
      vb = val_q.size(); tb = tx_q.size();
      send(8'h05); send(8'h00); send(8'h03);
      wait_tx(tb + 4, "vr_timeout");
      chk("vr_b0", txb(tb),     64'hDE);
      chk("vr_b1", txb(tb + 1), 64'hAD);
      chk("vr_b2", txb(tb + 2), 64'hBE);
      chk("vr_b3", txb(tb + 3), 64'hEF);
      chk("vr_pulse_n", 64'(val_q.size() - vb), 64'd1);
      chk("vr_pulse",   valb(vb), 64'({1'b1, 16'h0003, 32'h0}));

      // Unknown command
      tb = tx_q.size();
      send(8'h7F);
      wait_tx(tb + 1, "err_timeout");
      repeat (2) tick();
      chk("err_byte", txb(tb), 64'hEE);
      chk("err_n",    64'(tx_q.size() - tb), 64'd1);
      chk("err_busy", 64'(o_busy), 64'd0);

      // VALUE_WRITE id 7
      vb = val_q.size();
      send(8'h04); send(8'h00); send(8'h07);
      send(8'h12); send(8'h34); send(8'h56); send(8'h78);
      repeat (2) tick();
      chk("vw_n",     64'(val_q.size() - vb), 64'd1);
      chk("vw_pulse", valb(vb), 64'({1'b0, 16'h0007, 32'h12345678}));

      // MEM_READ with len 0
      rb = rd_n; tb = tx_q.size();
      send(8'h03); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      repeat (5) tick();
      chk("len0_rd", 64'(rd_n - rb), 64'd0);
      chk("len0_tx", 64'(tx_q.size() - tb), 64'd0);
      chk("len0_cmd", 64'(o_debug_cmd), 64'h00);

      // Reset after a MEM_WRITE header
      wb = wr_q.size();
      send(8'h02); send(8'h12); send(8'h34); send(8'h00); send(8'h02);
      chk("rstm_cmd", 64'(o_debug_cmd), 64'h02);
      i_reset_n = 1'b0;
      repeat (2) tick();
      chk("rstm_cmd0",   64'(o_debug_cmd), 64'h00);
      chk("rstm_remain", 64'(o_bytes_remaining), 64'd0);
      i_reset_n = 1'b1;
      tick();
      tb = tx_q.size();
      send(8'h01); send(8'h33);
      wait_tx(tb + 1, "rstm_timeout");
      repeat (2) tick();
      chk("rstm_echo",  txb(tb), 64'h33);
      chk("rstm_no_wr", 64'(wr_q.size() - wb), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
